// File: rtl/roll_history.sv
// Circular history of settled roll values, captured on each falling edge of
// i_changing, with prev/next browsing of the stored entries.
module roll_history #(
    parameter int DEPTH = 8,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [W-1:0]  i_value,
    input  logic          i_changing,
    input  logic          i_browse_prev,
    input  logic          i_browse_next,
    input  logic          i_clear,
    output logic [W-1:0]  o_shown,
    output logic [AW-1:0] o_age,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_new,
    output logic          o_repeat
);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic          changing_d;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] age;
    logic          new_q;
    logic          rep_q;

    logic          cap;
    logic [AW-1:0] newest_idx;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   age_inc;
    logic          step_prev;
    logic          step_next;

    assign cap        = changing_d & ~i_changing;
    assign newest_idx = wr_ptr - PTR_ONE;
    assign rd_idx     = wr_ptr - PTR_ONE - age;
    assign age_inc    = {1'b0, age} + (AW+1)'(1);
    assign step_prev  = i_browse_prev & ~i_browse_next & (age_inc < count);
    assign step_next  = i_browse_next & ~i_browse_prev & (age != '0);

    // History storage is never reset; empty state hides stale contents.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clear && cap) begin
            mem[wr_ptr] <= i_value;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            changing_d <= 1'b0;
            wr_ptr     <= '0;
            count      <= '0;
            age        <= '0;
            new_q      <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            changing_d <= i_changing;
            if (i_clear) begin
                wr_ptr <= '0;
                count  <= '0;
                age    <= '0;
                new_q  <= 1'b0;
                rep_q  <= 1'b0;
            end else if (cap) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= (count == FULL) ? count : count + (AW+1)'(1);
                age    <= '0;
                new_q  <= 1'b1;
                rep_q  <= (count != '0) && (i_value == mem[newest_idx]);
            end else begin
                new_q <= 1'b0;
                rep_q <= 1'b0;
                if (step_prev) begin
                    age <= age + PTR_ONE;
                end else if (step_next) begin
                    age <= age - PTR_ONE;
                end
            end
        end
    end

    assign o_empty  = (count == '0);
    assign o_shown  = o_empty ? '0 : mem[rd_idx];
    assign o_age    = age;
    assign o_count  = count;
    assign o_new    = new_q;
    assign o_repeat = rep_q & new_q;

endmodule

// File: doc/roll_history.md
# roll_history

Result logger that sits downstream of the lab1 random-roll generator. It watches the generator's 4-bit output and its "changing" flag, and captures the settled value each time a roll ends. Captured values go into a circular history of the last `DEPTH` rolls. Push-button pulses let the user browse the history; the selected entry is driven to the display path together with its age and the fill count.

## Interface
- `DEPTH`, 8: history entries; power of two, legal 2..16.
- `W`, 4: width of a roll value.
- `AW`, `$clog2(DEPTH)`: derived, not overridden.

- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_value`  in  W  roll value from the generator.
- `i_changing`  in  1  high while a roll is animating; a falling edge marks a settled result.
- `i_browse_prev`  in  1  one-cycle pulse: step to an older entry.
- `i_browse_next`  in  1  one-cycle pulse: step to a newer entry.
- `i_clear`  in  1  one-cycle pulse: empty the history.
- `o_shown`  out  W  value of the currently selected entry; 0 when empty.
- `o_age`  out  AW  age of the selected entry; 0 = newest.
- `o_count`  out  AW+1  number of valid entries, 0..DEPTH.
- `o_empty`  out  1  high when `o_count == 0`.
- `o_new`  out  1  one-cycle pulse in the cycle after a capture.
- `o_repeat`  out  1  valid while `o_new` is high; set when the captured value equals the previous newest entry.

## Operation
- **State:** `changing_d` (1b), `mem[DEPTH]` (W each), `wr_ptr` (AW), `count` (AW+1), `age` (AW), `new_q`, `rep_q`.
- **Capture condition:** `cap = changing_d & ~i_changing`, evaluated every cycle. `changing_d <= i_changing` every cycle.
- **Capture actions:**
  - `mem[wr_ptr] <= i_value`
  - `wr_ptr <= wr_ptr + 1`, wrapping mod DEPTH
  - `count <= min(count+1, DEPTH)`; at full, the oldest entry is overwritten
  - `age <= 0`
- **Repeat flag:** `rep_q <= (count != 0) & (i_value == mem[wr_ptr-1])`, sampled before the write.
- **Browse (only when no capture and no clear):**
  - `prev`: `age <= age+1` if `age+1 < count`, else hold (saturate at oldest).
  - `next`: `age <= age-1` if `age != 0`, else hold.
  - `prev` and `next` in the same cycle: no change.
  - Browse while empty: no change.
- **Priority, highest first:** `i_clear` > capture > browse.
- **Clear:**
  - `count`, `wr_ptr`, `age` go to 0; `new_q` and `rep_q` go to 0.
  - `mem` contents are left stale; they are unobservable because `o_shown` is forced to 0 when empty.
  - `changing_d` still tracks `i_changing`, but a capture in a clear cycle is dropped.
- **Outputs (pure functions of registers, no combinational input-to-output path):**
  - `o_shown = o_empty ? 0 : mem[wr_ptr-1-age]`, index mod DEPTH
  - `o_new = new_q`
  - `o_repeat = rep_q & new_q`
- **Arithmetic:** all pointer math is AW-bit modulo DEPTH. `count` is AW+1 bits and never exceeds DEPTH.

## Timing
- **Reset** (synchronous, `i_rst` high at an edge): every output is 0.
  - `o_shown` = 0, `o_age` = 0, `o_count` = 0, `o_empty` = 1, `o_new` = 0, `o_repeat` = 0.
  - `changing_d` = 0, so a low `i_changing` right after reset does not capture.
- **Reset mid-operation** (during a roll or while browsing): all history is discarded. If `i_changing` is still high when reset releases, its later fall is captured normally.
- **Capture latency:** fall observed in cycle t (`i_changing`=0, `changing_d`=1). In cycle t+1:
  - `o_shown` = captured value
  - `o_age` = 0, `o_count` is updated
  - `o_new` = 1 for exactly one cycle
- **Browse latency:** a pulse in cycle t updates `o_age` and `o_shown` in t+1.
- **Held inputs:** a browse input held high for k cycles steps k times, saturating. Debouncing and one-shot generation are upstream.
- **Clear latency:** a pulse in cycle t gives `o_empty`=1 in t+1.
- **Back-to-back rolls:** falls two cycles apart both capture, since every fall is preceded by a high cycle. No capture can be lost except to `i_clear`.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles mid-roll -> all outputs 0 and `o_empty`=1; drive `i_changing` low after release -> no `o_new`.
- **Single capture:** `i_value`=4'h9, `i_changing` 1->0 -> next cycle `o_shown`=9, `o_count`=1, `o_age`=0, `o_new` pulses once, `o_repeat`=0.
- **Wrap:** with DEPTH=8, capture 1..10 -> `o_count`=8, `o_shown`=10; 7 prev pulses -> `o_age`=7, `o_shown`=3; an 8th prev pulse -> still 7/3.
- **Browse and priority:** browse to age 2, then capture 4'h5 in the same cycle as `i_browse_prev` -> `o_age`=0, `o_shown`=5; next pulse at age 0 -> unchanged.
- **Repeat and clear:** capture 6 then 6 -> second `o_new` has `o_repeat`=1. Then `i_clear` together with a capture -> `o_empty`=1, `o_shown`=0, `o_new`=0.
- **Simultaneous prev+next:** pulse both at age 3 with count 5 -> `o_age` stays 3.
